// File: rtl/aes_spi_frame_slave_if.sv
//------------------------------------------------------------------------------
// aes_spi_frame_slave_if
// Command/result handshake bundle between the SPI frame endpoint and the AES
// core.
//   cmd_valid/cmd_ready      : command handshake (endpoint -> core)
//   cmd_text[127:0]          : plaintext/ciphertext block
//   cmd_key_size[7:0]        : key size byte
//   cmd_key[255:0]           : key material
//   rsp_valid/rsp_ready      : result handshake (core -> endpoint)
//   rsp_data[127:0]          : result block
// Modports:
//   slave  : the SPI frame endpoint (offers commands, accepts results)
//   master : the AES core side
//------------------------------------------------------------------------------
`timescale 1ns/1ps

interface aes_spi_frame_slave_if;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [127:0] cmd_text;
    logic [7:0]   cmd_key_size;
    logic [255:0] cmd_key;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [127:0] rsp_data;

    modport slave (
        output cmd_valid, cmd_text, cmd_key_size, cmd_key, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data
    );

    modport master (
        input  cmd_valid, cmd_text, cmd_key_size, cmd_key, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/aes_spi_frame_slave.sv
//------------------------------------------------------------------------------
// aes_spi_frame_slave
// SPI-slave (mode 0, MSB first) frame endpoint on the AES side of the link.
// Receives {text[127:0], key_size[7:0], key[255:0]} frames, hands complete
// frames to the AES core, and shifts the buffered 128-bit result back out,
// preceded by a status byte, during the next frame. All logic runs on clk
// with oversampled, synchronized SPI inputs.
// Parameters:
//   FRAME_BITS  : SPI bits per frame (392)
//   SYNC_STAGES : flops per cs/sclk/mosi synchronizer (>= 2)
// Ports:
//   clk, reset  : system clock, synchronous active-high reset
//   cs          : chip select, active low
//   sclk, mosi  : SPI clock and serial data in
//   miso        : serial data out, 0 when not in a frame
//   frame_err   : one-cycle pulse on a malformed frame
//   busy        : high while a frame is in progress
//   bus         : command/result handshake (slave modport)
// Build option:
//   AES_SPI_KEYSIZE_CHECK_EN : drop complete frames whose key size is not
//                              0x10/0x18/0x20 and flag status bit4.
// Status byte: {res_full, overflow, bad_frame, bad_key_size, accepted[3:0]}
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module aes_spi_frame_slave #(
    parameter int FRAME_BITS  = 392,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic cs,
    input  logic sclk,
    input  logic mosi,
    output logic miso,
    output logic frame_err,
    output logic busy,
    aes_spi_frame_slave_if.slave bus
);

    localparam int         TEXT_LSB  = FRAME_BITS - 128;
    localparam int         KS_LSB    = FRAME_BITS - 136;
    localparam logic [8:0] FRAME_CNT = 9'(FRAME_BITS);

    typedef enum logic [0:0] {ST_IDLE, ST_SHIFT} state_t;

    state_t r_state, w_state_next;

    // ---------------- input synchronizers and edge detect ----------------
    logic [SYNC_STAGES-1:0] r_cs_sync, r_sclk_sync, r_mosi_sync;
    logic [SYNC_STAGES:0]   r_sync_vld;
    logic r_cs_prev, r_sclk_prev;
    logic r_cs_fall, r_cs_rise, r_sclk_rise, r_sclk_fall;
    logic w_cs_s, w_sclk_s, w_mosi_s;

    assign w_cs_s   = r_cs_sync[SYNC_STAGES-1];
    assign w_sclk_s = r_sclk_sync[SYNC_STAGES-1];
    assign w_mosi_s = r_mosi_sync[SYNC_STAGES-1];

    // r_sync_vld tracks when the synchronizer and prev flops hold pin-derived
    // values, so a cs held low across reset is not mistaken for a falling edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cs_sync   <= '1;
            r_sclk_sync <= '0;
            r_mosi_sync <= '0;
            r_sync_vld  <= '0;
            r_cs_prev   <= 1'b1;
            r_sclk_prev <= 1'b0;
            r_cs_fall   <= 1'b0;
            r_cs_rise   <= 1'b0;
            r_sclk_rise <= 1'b0;
            r_sclk_fall <= 1'b0;
        end else begin
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], cs};
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
            r_sync_vld  <= {r_sync_vld[SYNC_STAGES-1:0], 1'b1};
            r_cs_prev   <= w_cs_s;
            r_sclk_prev <= w_sclk_s;
            r_cs_fall   <= r_sync_vld[SYNC_STAGES] &  r_cs_prev   & ~w_cs_s;
            r_cs_rise   <= r_sync_vld[SYNC_STAGES] & ~r_cs_prev   &  w_cs_s;
            r_sclk_rise <= r_sync_vld[SYNC_STAGES] & ~r_sclk_prev &  w_sclk_s;
            r_sclk_fall <= r_sync_vld[SYNC_STAGES] &  r_sclk_prev & ~w_sclk_s;
        end
    end

    // ---------------- frame FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_cs_fall) w_state_next = ST_SHIFT;
            end
            ST_SHIFT: begin
                busy = 1'b1;
                if (r_cs_rise) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // ---------------- datapath ----------------
    logic [FRAME_BITS-1:0] r_tx, r_rx;
    logic [8:0]   r_bit_cnt;
    logic [127:0] r_res_buf;
    logic         r_res_full, r_res_was_full;
    logic         r_ovf, r_bad_frame, r_bad_ks;
    logic [3:0]   r_acc_cnt;
    logic [2:0]   r_sent_sticky;
    logic         r_cmd_valid;
    logic [127:0] r_cmd_text;
    logic [7:0]   r_cmd_ks;
    logic [255:0] r_cmd_key;
    logic         r_frame_err;
    logic [7:0]   w_status;
    logic         w_rsp_ready;
    logic         w_ks_bad;

    assign w_status    = {r_res_full, r_ovf, r_bad_frame, r_bad_ks, r_acc_cnt};
    assign w_rsp_ready = ~r_res_full & (r_state == ST_IDLE) & ~r_cs_fall;

    always_comb begin
        w_ks_bad = 1'b0;
`ifdef AES_SPI_KEYSIZE_CHECK_EN
        w_ks_bad = !(r_rx[KS_LSB +: 8] inside {8'h10, 8'h18, 8'h20});
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_tx           <= '0;
            r_rx           <= '0;
            r_bit_cnt      <= '0;
            r_res_buf      <= '0;
            r_res_full     <= 1'b0;
            r_res_was_full <= 1'b0;
            r_ovf          <= 1'b0;
            r_bad_frame    <= 1'b0;
            r_bad_ks       <= 1'b0;
            r_acc_cnt      <= '0;
            r_sent_sticky  <= '0;
            r_cmd_valid    <= 1'b0;
            r_cmd_text     <= '0;
            r_cmd_ks       <= '0;
            r_cmd_key      <= '0;
            r_frame_err    <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;

            if (bus.rsp_valid && w_rsp_ready) begin
                r_res_buf  <= bus.rsp_data;
                r_res_full <= 1'b1;
            end

            // Handshake is processed before any load at cs rise below, so a
            // same-cycle accept frees the slot for the new frame.
            if (r_cmd_valid && bus.cmd_ready) begin
                r_cmd_valid <= 1'b0;
                r_acc_cnt   <= r_acc_cnt + 4'd1;
            end

            if (r_state == ST_IDLE && r_cs_fall) begin
                r_tx           <= {w_status, r_res_buf, {(FRAME_BITS-136){1'b0}}};
                r_bit_cnt      <= '0;
                r_sent_sticky  <= {r_ovf, r_bad_frame, r_bad_ks};
                r_res_was_full <= r_res_full;
            end

            if (r_state == ST_SHIFT) begin
                if (r_sclk_rise) begin
                    r_rx <= {r_rx[FRAME_BITS-2:0], w_mosi_s};
                    if (r_bit_cnt != '1) r_bit_cnt <= r_bit_cnt + 9'd1;
                end
                if (r_sclk_fall) r_tx <= {r_tx[FRAME_BITS-2:0], 1'b0};

                if (r_cs_rise) begin
                    // Sticky flags clear only once the whole status byte was
                    // clocked out; new events set below take priority.
                    if (r_bit_cnt >= 9'd8) begin
                        r_ovf       <= r_ovf       & ~r_sent_sticky[2];
                        r_bad_frame <= r_bad_frame & ~r_sent_sticky[1];
                        r_bad_ks    <= r_bad_ks    & ~r_sent_sticky[0];
                    end
                    if (r_bit_cnt != FRAME_CNT) begin
                        r_frame_err <= 1'b1;
                        r_bad_frame <= 1'b1;
                    end else begin
                        // Result counts as read; buffer is zeroed so the next
                        // readback shows an empty slot.
                        if (r_res_was_full) begin
                            r_res_full <= 1'b0;
                            r_res_buf  <= '0;
                        end
                        if (w_ks_bad) begin
                            r_bad_ks <= 1'b1;
                        end else if (r_cmd_valid && !bus.cmd_ready) begin
                            r_ovf <= 1'b1;
                        end else begin
                            r_cmd_valid <= 1'b1;
                            r_cmd_text  <= r_rx[TEXT_LSB +: 128];
                            r_cmd_ks    <= r_rx[KS_LSB +: 8];
                            r_cmd_key   <= r_rx[255:0];
                        end
                    end
                end
            end
        end
    end

    assign miso             = (r_state == ST_SHIFT) & r_tx[FRAME_BITS-1];
    assign frame_err        = r_frame_err;
    assign bus.cmd_valid    = r_cmd_valid;
    assign bus.cmd_text     = r_cmd_text;
    assign bus.cmd_key_size = r_cmd_ks;
    assign bus.cmd_key      = r_cmd_key;
    assign bus.rsp_ready    = w_rsp_ready;

endmodule

// File: tb/tb_aes_spi_frame_slave.sv
`timescale 1ns/1ps

module tb_aes_spi_frame_slave;

    logic clk = 1'b0;
    logic reset, cs, sclk, mosi, miso, frame_err, busy;

    always #5 clk = ~clk;

    aes_spi_frame_slave_if bus();

    aes_spi_frame_slave #(.FRAME_BITS(392), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset), .cs(cs), .sclk(sclk), .mosi(mosi),
        .miso(miso), .frame_err(frame_err), .busy(busy), .bus(bus)
    );

    typedef struct {
        logic [391:0] frame;
        int           nbits;
        bit           pre_ready;
        bit           pre_rsp;
        logic [7:0]   exp_st;
        logic [127:0] exp_res;
        logic         exp_valid;
        int           exp_err;
        logic [391:0] exp_cmd;
    } rec_t;

    localparam logic [127:0] RES = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;

    int checks = 0;
    int errors = 0;
    int err_pulses = 0;
    logic [391:0] g_tx, g_rx;
    rec_t tbl[9];

    always @(negedge clk) if (frame_err === 1'b1) err_pulses++;

    initial begin
        #3ms;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [391:0] act, input logic [391:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic rec_t mk(input logic [391:0] f, input int n, input bit pr, input bit ps,
                                input logic [7:0] st, input logic [127:0] res, input logic v,
                                input int e, input logic [391:0] c);
        rec_t r;
        r.frame = f; r.nbits = n; r.pre_ready = pr; r.pre_rsp = ps;
        r.exp_st = st; r.exp_res = res; r.exp_valid = v; r.exp_err = e; r.exp_cmd = c;
        return r;
    endfunction

    task automatic spi_begin();
        @(negedge clk);
        cs = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic spi_bits(input int first, input int n);
        for (int i = first; i < first + n; i++) begin
            mosi = g_tx[391-i];
            repeat (6) @(negedge clk);
            g_rx[391-i] = miso;
            sclk = 1'b1;
            repeat (6) @(negedge clk);
            sclk = 1'b0;
        end
    endtask

    task automatic spi_end();
        repeat (8) @(negedge clk);
        cs = 1'b1;
        repeat (12) @(negedge clk);
    endtask

    function automatic logic [391:0] cmd_now();
        return {bus.cmd_text, bus.cmd_key_size, bus.cmd_key};
    endfunction

    task automatic pulse_ready();
        chk("cmd_hold", bus.cmd_valid, 1'b1);
        repeat (3) @(negedge clk);
        chk("cmd_hold_later", bus.cmd_valid, 1'b1);
        bus.cmd_ready = 1'b1;
        @(negedge clk);
        chk("cmd_drop", bus.cmd_valid, 1'b0);
        bus.cmd_ready = 1'b0;
    endtask

    task automatic offer_rsp(input logic [127:0] d);
        chk("rsp_ready_before", bus.rsp_ready, 1'b1);
        bus.rsp_valid = 1'b1;
        bus.rsp_data  = d;
        @(negedge clk);
        chk("rsp_ready_after", bus.rsp_ready, 1'b0);
        bus.rsp_valid = 1'b0;
    endtask

    task automatic run_rec(input rec_t r);
        int e0;
        if (r.pre_ready) pulse_ready();
        if (r.pre_rsp) offer_rsp(RES);
        g_tx = r.frame;
        g_rx = '0;
        e0 = err_pulses;
        spi_begin();
        chk("busy_in_frame", busy, 1'b1);
        spi_bits(0, r.nbits);
        spi_end();
        chk("status_byte", g_rx[391:384], r.exp_st);
        if (r.nbits == 392) begin
            chk("res_data", g_rx[383:256], r.exp_res);
            chk("tail_zero", g_rx[255:0], '0);
        end
        chk("frame_err_cnt", err_pulses - e0, r.exp_err);
        chk("cmd_valid", bus.cmd_valid, r.exp_valid);
        chk("cmd_fields", cmd_now(), r.exp_cmd);
        chk("miso_idle", miso, 1'b0);
        chk("busy_idle", busy, 1'b0);
    endtask

    initial begin
        logic [391:0] fa, fd, fd2, fs, fe, ff, fp, fg, fh, fz;
        int e0;

        cs = 1'b1; sclk = 1'b0; mosi = 1'b0; reset = 1'b1;
        bus.cmd_ready = 1'b0; bus.rsp_valid = 1'b0; bus.rsp_data = '0;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        chk("rst_miso", miso, 1'b0);
        chk("rst_cmd_valid", bus.cmd_valid, 1'b0);
        chk("rst_rsp_ready", bus.rsp_ready, 1'b1);
        chk("rst_frame_err", frame_err, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_cmd_fields", cmd_now(), '0);

        fa  = {128'h00112233445566778899aabbccddeeff, 8'h18,
               192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
        fd  = {{16{8'h5a}}, 8'h10, {32{8'hc3}}};
        fd2 = {{16{8'h96}}, 8'h20, {32{8'h17}}};
        fs  = {{16{8'he1}}, 8'h18, {32{8'h2d}}};
        fe  = {{8{16'hbeef}}, 8'h20, {16{16'h1234}}};
        ff  = {{4{32'hcafef00d}}, 8'h10, {8{32'h0badc0de}}};
        fp  = {{16{8'h3c}}, 8'h18, {32{8'h81}}};
        fg  = {{16{8'h0f}}, 8'h20, {32{8'hf0}}};
        fh  = {{16{8'h77}}, 8'h11, {32{8'h88}}};
        fz  = {{16{8'h42}}, 8'h20, {32{8'h24}}};

        //            frame nbits rdy rsp status res  valid err cmd
        tbl[0] = mk(fa,  392, 0, 0, 8'h00, '0,  1'b1, 0, fa);
        tbl[1] = mk(fd,  392, 1, 1, 8'h81, RES, 1'b1, 0, fd);
        tbl[2] = mk(fd2, 392, 0, 0, 8'h01, '0,  1'b1, 0, fd);
        tbl[3] = mk(fs,  100, 0, 0, 8'h41, '0,  1'b1, 1, fd);
        tbl[4] = mk(fe,  392, 1, 0, 8'h22, '0,  1'b1, 0, fe);
        tbl[5] = mk(fp,  392, 1, 0, 8'h04, '0,  1'b1, 0, fp);
        tbl[6] = mk(fg,  392, 0, 0, 8'h00, '0,  1'b1, 0, fg);
`ifdef AES_SPI_KEYSIZE_CHECK_EN
        tbl[7] = mk(fh,  392, 1, 0, 8'h01, '0,  1'b0, 0, fg);
        tbl[8] = mk(fz,  392, 0, 0, 8'h11, '0,  1'b1, 0, fz);
`else
        tbl[7] = mk(fh,  392, 1, 0, 8'h01, '0,  1'b1, 0, fh);
        tbl[8] = mk(fz,  392, 1, 0, 8'h02, '0,  1'b1, 0, fz);
`endif

        for (int i = 0; i < 5; i++) run_rec(tbl[i]);

        // cmd_ready handshake lands in the same cycle as the cs-rise load.
        g_tx = ff; g_rx = '0; e0 = err_pulses;
        spi_begin();
        spi_bits(0, 392);
        repeat (8) @(negedge clk);
        cs = 1'b1;
        repeat (3) @(negedge clk);
        chk("lat_cmd_not_yet", cmd_now(), fe);
        chk("lat_valid_held", bus.cmd_valid, 1'b1);
        bus.cmd_ready = 1'b1;
        @(negedge clk);
        bus.cmd_ready = 1'b0;
        chk("sim_valid", bus.cmd_valid, 1'b1);
        chk("sim_cmd", cmd_now(), ff);
        repeat (8) @(negedge clk);
        chk("sim_status", g_rx[391:384], 8'h02);
        chk("sim_frame_err", err_pulses - e0, 0);

        run_rec(tbl[5]);

        // Reset in the middle of a frame, cs stays low through reset.
        g_tx = fg; g_rx = '0; e0 = err_pulses;
        spi_begin();
        spi_bits(0, 200);
        chk("mid_busy", busy, 1'b1);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("mid_rst_cmd_valid", bus.cmd_valid, 1'b0);
        chk("mid_rst_cmd_fields", cmd_now(), '0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_miso", miso, 1'b0);
        chk("mid_rst_rsp_ready", bus.rsp_ready, 1'b1);
        spi_bits(200, 192);
        chk("mid_stay_idle", busy, 1'b0);
        spi_end();
        chk("mid_no_frame_err", err_pulses - e0, 0);
        chk("mid_no_cmd", bus.cmd_valid, 1'b0);

        for (int i = 6; i < 9; i++) run_rec(tbl[i]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/aes_spi_frame_slave.md
# aes_spi_frame_slave

SPI-slave frame endpoint on the AES side of the link. It receives 392-bit command frames of the form {plaintext/ciphertext[127:0], key_size[7:0], key[255:0]} from the SPI master. It hands each complete frame to the AES core over a valid/ready handshake, and it shifts the core's buffered 128-bit result back out on MISO during the next frame. It sits between the pins `cs`/`sclk`/`mosi`/`miso` and the AES datapath, and all logic runs on `clk` with oversampled SPI inputs.

## Interface
- `FRAME_BITS`, 392: SPI bits per frame.
- `SYNC_STAGES`, 2: flops in each `cs`/`sclk`/`mosi` synchronizer (minimum 2).
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `cs` in 1: SPI chip select, active low.
- `sclk` in 1: SPI clock, mode 0 (CPOL=0, CPHA=0).
- `mosi` in 1: serial data in, MSB first.
- `miso` out 1: serial data out, MSB first. Driven 0 while `cs` is high.
- `cmd_valid` out 1: a command is held on the `cmd_*` outputs.
- `cmd_ready` in 1: the core accepts the command.
- `cmd_text` out 128: frame bits [391:264].
- `cmd_key_size` out 8: frame bits [263:256].
- `cmd_key` out 256: frame bits [255:0].
- `rsp_valid` in 1: the core offers a result.
- `rsp_ready` out 1: the result slot can accept.
- `rsp_data` in 128: result block.
- `frame_err` out 1: one-cycle pulse on a malformed frame.
- `busy` out 1: high when state is not IDLE.

## Operation
- States:
  - IDLE to SHIFT on a synced `cs` falling edge.
  - SHIFT to IDLE on a synced `cs` rising edge.
  - There is no separate state for the pending command. The command register is independent: `cmd_valid` is held until `cmd_valid & cmd_ready`.
- On `cs` fall:
  - Load the tx shift register with {status[7:0], res_buf[127:0], 256'h0}.
  - Drive `miso` = bit 391.
  - Clear the rx bit counter.
- On each synced `sclk` rise in SHIFT: rx = {rx[390:0], mosi_sync}, and the counter increments. The counter saturates at 511.
- On each synced `sclk` fall in SHIFT: shift tx left and drive the new bit 391 on `miso`.
- Status byte:
  - bit7 = res_full.
  - bit6 = overflow: a command was dropped because `cmd_valid` was still high.
  - bit5 = the last frame was malformed.
  - bit4 = bad key size.
  - bits3:0 = count of accepted commands, mod 16.
  - Bits 6–4 are sticky. They clear at the end of the next frame that shifted them out.
- On `cs` rise:
  - If count ≠ 392: pulse `frame_err`, set bit5, discard the frame.
  - Otherwise, if `cmd_valid` is high: set bit6 and drop the frame.
  - Otherwise: load the `cmd_*` outputs from rx and set `cmd_valid`.
  - Separately, if res_full was 1 at the `cs` fall and count = 392, clear res_full. The result counts as read.
- Result slot:
  - `rsp_ready` = ~res_full & (state == IDLE) & ~cs_fall_detect.
  - On `rsp_valid & rsp_ready`: res_buf ← `rsp_data` and res_full ← 1.
- Simultaneous events:
  - A `cs` fall and a result offer in the same cycle: the fall wins and the result waits.
  - A `cmd_ready` handshake and a `cs` rise in the same cycle: the handshake completes first, so the new frame is accepted without overflow.
- Reset mid-frame: all state is cleared and the partial frame is discarded silently, with no `frame_err`. If `cs` is already low when reset deasserts, the block stays in IDLE until the next falling edge.

## Timing
- Reset values:
  - `miso`, `cmd_valid`, `rsp_ready` (combinationally 1 after reset), `frame_err`, `busy`: `miso`, `cmd_valid`, `frame_err` and `busy` = 0.
  - `cmd_*` data = 0.
  - res_buf = 0 and status = 0.
  - Synchronizers reset to `cs` = 1 and `sclk` = 0.
- `sclk` high and low phases must each last at least 3 `clk` periods. The `cs` setup before the first `sclk` rise, and the hold after the last fall, must each be at least 4 `clk` periods.
- Pin `cs` rise to `cmd_valid` high: SYNC_STAGES + 2 cycles. `frame_err` has the same latency.
- `miso` changes SYNC_STAGES + 2 cycles after a pin `sclk` fall. This is stable well before the next rise at the minimum phase length.
- `rsp_valid` to res_full: 1 cycle.

## Configuration
- `AES_SPI_KEYSIZE_CHECK_EN` defined:
  - A complete frame with `cmd_key_size` ∉ {0x10, 0x18, 0x20} is dropped.
  - Status bit4 is set.
  - No `cmd_valid` is raised and no `frame_err` is pulsed.
- Undefined: every 392-bit frame is forwarded. Bit4 reads 0.

## Test plan
- Command acceptance:
  - Stimulus: frame {00112233445566778899aabbccddeeff, 0x18, 000102…1617 followed by 64'h0}.
  - Response: `cmd_valid` rises with `cmd_text` = 00112233…eeff, `cmd_key_size` = 0x18 and the `cmd_key` as sent. It holds until `cmd_ready` and then drops in 1 cycle.
- Result readback:
  - Stimulus: `rsp_data` = dda97ca4864cdfe06eaf70a0ec0d7191, then a dummy frame.
  - Response: `miso` carries status 0x81 followed by dda97ca4…7191 and then 256 zeros. After that frame a second read returns status 0x01 with zeros.
- Short frame:
  - Stimulus: `cs` low for 100 `sclk` edges.
  - Response: one `frame_err` pulse, no `cmd_valid`, and bit5 set in the next status byte.
- Overflow:
  - Stimulus: two complete frames with `cmd_ready` held 0.
  - Response: the first command is held unchanged and the next status byte shows bit6 = 1.
- Key size check, with `AES_SPI_KEYSIZE_CHECK_EN` defined:
  - Stimulus: key_size 0x11.
  - Response: no `cmd_valid` and status bit4 = 1.
- Reset mid-frame:
  - Stimulus: `reset` at bit 200.
  - Response: outputs return to reset values with no `frame_err`. The next full frame is accepted normally.
